// File: rtl/alsu_if.sv
// Request/result bundle between an ALSU requester and alsu_seq.
// The requester drives the operands and flags; alsu_seq returns registered results.
interface alsu_if #(
    parameter int WIDTH = 4
);
    logic               start;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [2:0]         Opcode;
    logic               Cin;
    logic               red_op_A;
    logic               red_op_B;
    logic               bypass_A;
    logic               bypass_B;
    logic               direction;
    logic               serial_in;
    logic [2*WIDTH-1:0] out;
    logic [WIDTH-1:0]   remainder;
    logic               Odd_parity;
    logic               Invalid;
    logic               busy;
    logic               done;

    modport master (
        output start, A, B, Opcode, Cin, red_op_A, red_op_B,
               bypass_A, bypass_B, direction, serial_in,
        input  out, remainder, Odd_parity, Invalid, busy, done
    );

    modport slave (
        input  start, A, B, Opcode, Cin, red_op_A, red_op_B,
               bypass_A, bypass_B, direction, serial_in,
        output out, remainder, Odd_parity, Invalid, busy, done
    );
endinterface

// File: rtl/alsu_seq.sv
// Sequential ALSU: single-cycle logic/arithmetic/shift ops plus a WIDTH-cycle
// restoring divider. Results and flags are registered and announced by a done pulse.
module alsu_seq #(
    parameter int WIDTH          = 4,
    parameter     INPUT_PRIORITY = "A",
    parameter     FULL_ADDER     = "ON"
) (
    input logic   clk,
    input logic   rst_n,
    alsu_if.slave bus
);
    localparam int OUT_W   = 2 * WIDTH;
    localparam int CNT_W   = $clog2(WIDTH + 1);
    localparam bit PRIO_B  = (INPUT_PRIORITY == "B");
    localparam bit ADD_CIN = (FULL_ADDER == "ON");

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] DIV  = 1'b1;

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_XOR   = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_MULT  = 3'b011;
    localparam logic [2:0] OP_ABS   = 3'b100;
    localparam logic [2:0] OP_DIV   = 3'b101;
    localparam logic [2:0] OP_SHIFT = 3'b110;
    localparam logic [2:0] OP_ROT   = 3'b111;

    logic [0:0]       state;
    logic [OUT_W-1:0] out_q;
    logic [WIDTH-1:0] rem_q;
    logic             parity_q;
    logic             invalid_q;
    logic             done_q;

    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem_acc;
    logic [WIDTH-1:0] divisor;
    logic [CNT_W-1:0] cnt;
    logic             div_invalid;

    logic [OUT_W-1:0] nxt_out;
    logic             nxt_parity;
    logic             nxt_invalid;
    logic             start_div;
    logic             fill;

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] step_rem;

    logic [WIDTH-1:0] prio_op;
    assign prio_op = PRIO_B ? bus.B : bus.A;

    function automatic logic reduce_op(input logic [WIDTH-1:0] v, input logic use_and);
        return use_and ? &v : ^v;
    endfunction

    // Result of any op that completes on the accepting edge.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        nxt_out     = '0;
        nxt_parity  = 1'b0;
        nxt_invalid = 1'b0;
        start_div   = 1'b0;
        fill        = 1'b0;
        if (bus.bypass_A | bus.bypass_B) begin
            if (bus.bypass_A & bus.bypass_B) nxt_out = OUT_W'(prio_op);
            else if (bus.bypass_A)           nxt_out = OUT_W'(bus.A);
            else                             nxt_out = OUT_W'(bus.B);
        end else begin
            nxt_invalid = (bus.red_op_A | bus.red_op_B) & (bus.Opcode >= OP_ADD);
            case (bus.Opcode)
                OP_AND, OP_XOR: begin
                    if (bus.red_op_A & bus.red_op_B) begin
                        nxt_out     = OUT_W'(reduce_op(prio_op, bus.Opcode == OP_AND));
                        nxt_invalid = 1'b1;
                    end else if (bus.red_op_A) begin
                        nxt_out = OUT_W'(reduce_op(bus.A, bus.Opcode == OP_AND));
                    end else if (bus.red_op_B) begin
                        nxt_out = OUT_W'(reduce_op(bus.B, bus.Opcode == OP_AND));
                    end else begin
                        nxt_out = (bus.Opcode == OP_AND) ? OUT_W'(bus.A & bus.B)
                                                         : OUT_W'(bus.A ^ bus.B);
                    end
                end
                OP_ADD:  nxt_out = OUT_W'(bus.A) + OUT_W'(bus.B) + OUT_W'(bus.Cin & ADD_CIN);
                OP_MULT: nxt_out = OUT_W'(bus.A) * OUT_W'(bus.B);
                OP_ABS:  nxt_out = (bus.A >= bus.B) ? OUT_W'(bus.A - bus.B) : OUT_W'(bus.B - bus.A);
                OP_DIV: begin
                    // Zero divisor resolves immediately; only a real division iterates.
                    if (bus.B != '0)      start_div = 1'b1;
                    else if (bus.A != '0) begin
                        nxt_out     = '1;
                        nxt_invalid = 1'b1;
                    end
                end
                OP_SHIFT, OP_ROT: begin
                    if (bus.Opcode == OP_SHIFT) fill = bus.serial_in;
                    else                        fill = bus.direction ? bus.A[WIDTH-1] : bus.A[0];
                    nxt_out = bus.direction ? OUT_W'({bus.A[WIDTH-2:0], fill})
                                            : OUT_W'({fill, bus.A[WIDTH-1:1]});
                end
                default: nxt_out = '0;
            endcase
            if (bus.Opcode >= OP_ADD && bus.Opcode <= OP_DIV) nxt_parity = ~^nxt_out;
        end
    end

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        shifted = {rem_acc, quo[WIDTH-1]};
        if (shifted >= {1'b0, divisor}) begin
            step_rem = shifted[WIDTH-1:0] - divisor;
            step_quo = {quo[WIDTH-2:0], 1'b1};
        end else begin
            step_rem = shifted[WIDTH-1:0];
            step_quo = {quo[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            out_q       <= '0;
            rem_q       <= '0;
            parity_q    <= 1'b0;
            invalid_q   <= 1'b0;
            done_q      <= 1'b0;
            quo         <= '0;
            rem_acc     <= '0;
            divisor     <= '0;
            cnt         <= '0;
            div_invalid <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            done_q <= 1'b0;
            if (state == IDLE) begin
                if (bus.start) begin
                    if (start_div) begin
                        state       <= DIV;
                        quo         <= bus.A;
                        rem_acc     <= '0;
                        divisor     <= bus.B;
                        cnt         <= '0;
                        div_invalid <= nxt_invalid;
                    end else begin
                        out_q     <= nxt_out;
                        rem_q     <= '0;
                        parity_q  <= nxt_parity;
                        invalid_q <= nxt_invalid;
                        done_q    <= 1'b1;
                    end
                end
            end else begin
                quo     <= step_quo;
                rem_acc <= step_rem;
                cnt     <= cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state     <= IDLE;
                    out_q     <= OUT_W'(step_quo);
                    rem_q     <= step_rem;
                    parity_q  <= ~^step_quo;
                    invalid_q <= div_invalid;
                    done_q    <= 1'b1;
                end
            end
        end
    end

    assign bus.out        = out_q;
    assign bus.remainder  = rem_q;
    assign bus.Odd_parity = parity_q;
    assign bus.Invalid    = invalid_q;
    assign bus.busy       = (state == DIV);
    assign bus.done       = done_q;
endmodule

// File: tb/tb_alsu_seq.sv
// Self-checking bench for alsu_seq (WIDTH=4): directed corner cases plus random ops
// compared against an arithmetic reference model.
module tb_alsu_seq;
    localparam int W      = 4;
    localparam int OUT_W  = 2 * W;
    localparam int MASK   = (1 << W) - 1;
    localparam bit PRIO_B = 1'b0;
    localparam bit FULL   = 1'b1;

    typedef struct {
        logic [2:0]   opc;
        logic [W-1:0] a, b;
        logic         cin, ra, rb, ba, bb, dir, sin;
    } op_t;

    typedef struct {
        logic [OUT_W-1:0] out;
        logic [W-1:0]     rem;
        logic             par, inv;
        int               edges;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    logic [OUT_W-1:0] last_out;

    alsu_if #(.WIDTH(W)) bus ();

    alsu_seq #(.WIDTH(W), .INPUT_PRIORITY("A"), .FULL_ADDER("ON")) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int red(input int opc, input int v);
        return (opc == 0) ? int'(v == MASK) : ($countones(v) % 2);
    endfunction

    function automatic exp_t model(input op_t t);
        exp_t m;
        int a = int'(t.a);
        int b = int'(t.b);
        int s = int'(t.sin);
        int res = 0;
        m.rem = '0; m.inv = 1'b0; m.par = 1'b0; m.edges = 0;
        if (t.ba || t.bb) begin
            if (t.ba && t.bb) res = PRIO_B ? b : a;
            else              res = t.ba ? a : b;
        end else begin
            case (int'(t.opc))
                0, 1: begin
                    if (t.ra && t.rb) begin
                        res = red(int'(t.opc), PRIO_B ? b : a);
                        m.inv = 1'b1;
                    end else if (t.ra) res = red(int'(t.opc), a);
                    else if (t.rb)     res = red(int'(t.opc), b);
                    else               res = (t.opc == 0) ? (a & b) : (a ^ b);
                end
                2: res = a + b + (FULL ? int'(t.cin) : 0);
                3: res = a * b;
                4: res = (a >= b) ? a - b : b - a;
                5: begin
                    if (b == 0) begin
                        res = (a == 0) ? 0 : (1 << OUT_W) - 1;
                        if (a != 0) m.inv = 1'b1;
                    end else begin
                        res = a / b;
                        m.rem = W'(a % b);
                        m.edges = W;
                    end
                end
                6: res = t.dir ? (((a << 1) & MASK) | s) : ((a >> 1) | (s << (W - 1)));
                default: res = t.dir ? (((a << 1) & MASK) | (a >> (W - 1)))
                                     : ((a >> 1) | ((a & 1) << (W - 1)));
            endcase
            if (t.opc >= 2 && (t.ra || t.rb)) m.inv = 1'b1;
            if (t.opc >= 2 && t.opc <= 5) m.par = ($countones(res) % 2 == 0);
        end
        m.out = OUT_W'(res);
        return m;
    endfunction

    function automatic op_t rand_op();
        op_t t;
        t.opc = 3'($urandom_range(0, 7));
        t.a   = W'($urandom);
        t.b   = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
        t.cin = 1'($urandom);
        t.ra  = ($urandom_range(0, 3) == 0);
        t.rb  = ($urandom_range(0, 3) == 0);
        t.ba  = ($urandom_range(0, 7) == 0);
        t.bb  = ($urandom_range(0, 7) == 0);
        t.dir = 1'($urandom);
        t.sin = 1'($urandom);
        return t;
    endfunction

    function automatic op_t mk(input logic [2:0] opc, input logic [W-1:0] a, b);
        op_t t;
        t.opc = opc; t.a = a; t.b = b;
        t.cin = 1'b0; t.ra = 1'b0; t.rb = 1'b0; t.ba = 1'b0; t.bb = 1'b0;
        t.dir = 1'b0; t.sin = 1'b0;
        return t;
    endfunction

    task automatic drive(input op_t t);
        bus.Opcode    = t.opc;
        bus.A         = t.a;
        bus.B         = t.b;
        bus.Cin       = t.cin;
        bus.red_op_A  = t.ra;
        bus.red_op_B  = t.rb;
        bus.bypass_A  = t.ba;
        bus.bypass_B  = t.bb;
        bus.direction = t.dir;
        bus.serial_in = t.sin;
        bus.start     = 1'b1;
    endtask

    // Issue one op, optionally hammering start while busy, and compare on done.
    task automatic run_op(input string tag, input op_t t, input bit noise);
        exp_t e = model(t);
        int edges = 0;
        int busy_n = 0;
        drive(t);
        @(posedge clk); #1;
        bus.start = 1'b0;
        while (!bus.done && edges < 20) begin
            busy_n += int'(bus.busy);
            if (noise && bus.busy) drive(rand_op());
            @(posedge clk); #1;
            edges++;
        end
        bus.start = 1'b0;
        check({tag, " done"},   32'(bus.done),       32'd1);
        check({tag, " edges"},  32'(edges),          32'(e.edges));
        check({tag, " busy"},   32'(busy_n),         32'(e.edges));
        check({tag, " out"},    32'(bus.out),        32'(e.out));
        check({tag, " rem"},    32'(bus.remainder),  32'(e.rem));
        check({tag, " parity"}, 32'(bus.Odd_parity), 32'(e.par));
        check({tag, " inv"},    32'(bus.Invalid),    32'(e.inv));
        last_out = e.out;
    endtask

    task automatic idle_check(input string tag);
        @(posedge clk); #1;
        check({tag, " done_low"}, 32'(bus.done), 32'd0);
        check({tag, " hold"},     32'(bus.out),  32'(last_out));
    endtask

    initial begin
        op_t t;
        int dn;
        drive(mk(3'b000, '0, '0));
        bus.start = 1'b0;
        #3;
        check("rst out",    32'(bus.out),        32'd0);
        check("rst rem",    32'(bus.remainder),  32'd0);
        check("rst parity", 32'(bus.Odd_parity), 32'd0);
        check("rst inv",    32'(bus.Invalid),    32'd0);
        check("rst busy",   32'(bus.busy),       32'd0);
        check("rst done",   32'(bus.done),       32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        t = mk(3'b010, 4'hF, 4'h1); t.cin = 1'b1;
        run_op("add_f_1_c", t, 1'b0);
        check("add_f_1_c const", 32'(bus.out), 32'h11);
        idle_check("after_add");

        run_op("div_13_4", mk(3'b101, 4'd13, 4'd4), 1'b1);
        check("div_13_4 const", 32'(bus.out), 32'd3);
        check("div_13_4 busy_at_done", 32'(bus.busy), 32'd0);
        idle_check("after_div");

        run_op("div_15_0", mk(3'b101, 4'd15, 4'd0), 1'b0);
        check("div_15_0 const", 32'(bus.out), 32'hFF);
        t = mk(3'b101, 4'd0, 4'd0);
        run_op("div_0_0", t, 1'b0);
        t.ra = 1'b1;
        run_op("div_0_0_red", t, 1'b0);

        t = mk(3'b000, 4'hF, 4'h0); t.ra = 1'b1; t.rb = 1'b1;
        run_op("and_red_both", t, 1'b0);
        check("and_red_both const", 32'(bus.out), 32'd1);
        t = mk(3'b011, 4'h5, 4'hA); t.ba = 1'b1; t.bb = 1'b1;
        run_op("bypass_both", t, 1'b0);
        check("bypass_both const", 32'(bus.out), 32'h05);

        t = mk(3'b110, 4'b1001, 4'h0); t.dir = 1'b1; t.sin = 1'b1;
        run_op("shift_left", t, 1'b0);
        check("shift_left const", 32'(bus.out), 32'h03);
        t.rb = 1'b1;
        run_op("shift_left_red", t, 1'b0);
        t = mk(3'b111, 4'b0001, 4'h0); t.rb = 1'b1;
        run_op("rot_right_red", t, 1'b0);
        check("rot_right_red const", 32'(bus.out), 32'h08);

        for (int i = 0; i < 60; i++) begin
            run_op($sformatf("rand%0d", i), rand_op(), 1'b1);
            if (i % 3 == 0) idle_check($sformatf("rand%0d", i));
        end

        // Reset during the second division iteration.
        drive(mk(3'b101, 4'd13, 4'd4));
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        check("mid_div busy", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst out",    32'(bus.out),        32'd0);
        check("mid_rst rem",    32'(bus.remainder),  32'd0);
        check("mid_rst parity", 32'(bus.Odd_parity), 32'd0);
        check("mid_rst inv",    32'(bus.Invalid),    32'd0);
        check("mid_rst busy",   32'(bus.busy),       32'd0);
        check("mid_rst done",   32'(bus.done),       32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        dn = 0;
        repeat (6) begin
            @(posedge clk); #1;
            dn += int'(bus.done);
        end
        check("post_rst no_done", 32'(dn), 32'd0);
        run_op("mult_f_f", mk(3'b011, 4'hF, 4'hF), 1'b0);
        check("mult_f_f const", 32'(bus.out), 32'hE1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alsu_seq.md
ALSU_SEQ -- requirements
Module: alsu_seq

Interface
REQ-001 Parameter WIDTH, default 4: operand width A/B; out width 2*WIDTH.
REQ-002 Parameter INPUT_PRIORITY, default "A": operand winning on bypass/reduction conflict ("A" or "B").
REQ-003 Parameter FULL_ADDER, default "ON": "ON" adds Cin; "OFF" ignores Cin.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  request; accepted on a rising edge when busy=0.
REQ-007 A, B  in  WIDTH  operands, sampled on accept.
REQ-008 Opcode  in  3  000 AND, 001 XOR, 010 ADD, 011 MULT, 100 ABSDIFF, 101 DIV, 110 SHIFT, 111 ROTATE.
REQ-009 Cin, red_op_A, red_op_B, bypass_A, bypass_B, direction, serial_in  in  1 each  sampled on accept; direction 1 = left.
REQ-010 out  out  2*WIDTH  registered result.
REQ-011 remainder  out  WIDTH  registered DIV remainder; 0 for other ops.
REQ-012 Odd_parity, Invalid  out  1 each  registered flags.
REQ-013 busy  out  1  high while a DIV iterates.
REQ-014 done  out  1  one-cycle pulse when results update.

Function
REQ-015 FSM states IDLE, DIV; IDLE->DIV on accepting DIV with B!=0; DIV->IDLE after WIDTH iterations; busy = (state==DIV).
REQ-016 Non-DIV ops, DIV with B==0: out/remainder/flags written on accepting edge, done=1 next cycle (latency 1), FSM stays IDLE.
REQ-017 DIV with B!=0: restoring divider, one quotient bit per edge; results written and done pulsed on the WIDTH-th edge after accept (latency WIDTH).
REQ-018 start while busy=1 ignored, no effect on in-flight op; start while done=1 and busy=0 accepted (back-to-back).
REQ-019 Outputs hold last result until next write; done=0 on all other cycles.
REQ-020 bypass_A xor bypass_B: out = zero-extended selected operand; both set: INPUT_PRIORITY operand; Invalid=0, Odd_parity=0, latency 1; overrides Opcode.
REQ-021 AND/XOR: red_op_A -> out = reduction of A; red_op_B -> reduction of B; both -> INPUT_PRIORITY operand reduced, Invalid=1; neither -> bitwise A op B zero-extended.
REQ-022 ADD: out = A+B(+Cin if FULL_ADDER="ON"), carry kept in out[WIDTH].
REQ-023 MULT: out = A*B unsigned, full 2*WIDTH.
REQ-024 ABSDIFF: out = |A-B| unsigned.
REQ-025 DIV: A=0,B=0 -> out=0, remainder=0, Invalid per REQ-027 only; B=0,A!=0 -> out all ones, remainder=0, Invalid=1; else out=A/B, remainder=A%B.
REQ-026 SHIFT/ROTATE by one on A: left shifts serial_in into bit0, right into bit WIDTH-1; rotate recirculates; out zero-extended.
REQ-027 red_op_A or red_op_B with Opcode 010-111 (no bypass) -> Invalid=1, out still computed.
REQ-028 Odd_parity = XNOR-reduction of out for Opcodes 010-101, else 0.
REQ-029 All arithmetic unsigned; no truncation inside 2*WIDTH.

Reset
REQ-030 rst_n=0 immediately: state=IDLE, out=0, remainder=0, Odd_parity=0, Invalid=0, busy=0, done=0, divider/counter cleared.
REQ-031 Reset mid-DIV aborts op; no done after release; next start handled normally.

Verification (WIDTH=4)
REQ-032 Reset, then ADD A=F,B=1,Cin=1 -> 1 edge later out=8'h11, Odd_parity=1, Invalid=0, done one cycle.
REQ-033 DIV A=13,B=4 -> busy 4 cycles, done on 4th edge, out=3, remainder=1, Odd_parity=1; start pulses while busy ignored.
REQ-034 DIV A=15,B=0 -> latency 1, out=8'hFF, Invalid=1, busy stays 0.
REQ-035 AND with red_op_A=red_op_B=1, A=F,B=0 -> out=1, Invalid=1; bypass_A=bypass_B=1, A=5,B=A -> out=8'h05.
REQ-036 SHIFT left A=4'b1001, serial_in=1 -> out=8'h03; ROTATE right A=4'b0001 -> out=8'h08; either with red_op_B=1 -> Invalid=1.
REQ-037 rst_n low on 2nd DIV iteration -> all outputs 0 at once, no done; then MULT A=F,B=F -> out=8'hE1.
